// File: rtl/square_motion_engine_if.sv
// Frame-strobe control and published square coordinates between the motion
// engine and whoever drives frame timing and consumes the coords.
interface square_motion_engine_if #(
    parameter int unsigned N_OBJ = 5
) ();
    logic                 frame_tick;
    logic                 freeze;
    logic                 busy;
    logic                 update_done;
    logic                 overrun;
    logic [N_OBJ*10-1:0]  obj_x;
    logic [N_OBJ*10-1:0]  obj_y;
    logic [N_OBJ*2-1:0]   obj_dir;

    modport master (
        output frame_tick, freeze,
        input  busy, update_done, overrun, obj_x, obj_y, obj_dir
    );

    modport slave (
        input  frame_tick, freeze,
        output busy, update_done, overrun, obj_x, obj_y, obj_dir
    );
endinterface

// File: rtl/square_motion_engine.sv
// Once-per-frame position stepper for N_OBJ bouncing squares; sweeps one square
// per cycle into work regs, then publishes all coords at once.
module square_motion_engine #(
    parameter int unsigned N_OBJ = 5,
    parameter int unsigned H_RES = 640,
    parameter int unsigned V_RES = 480,
    parameter int unsigned SIZE  = 80
) (
    input  logic                    clk,
    input  logic                    rst_n,
    square_motion_engine_if.slave   bus
);
    localparam int unsigned IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
    localparam int unsigned PW    = 10;
    localparam int unsigned AW    = 11;
    localparam logic [AW-1:0] XMAX = AW'(H_RES - SIZE);
    localparam logic [AW-1:0] YMAX = AW'(V_RES - SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OBJ - 1);

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_COMMIT} state_t;

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_update_done, w_done_nxt;
    logic               r_overrun, w_ovr_nxt;
    logic               w_step_en, w_publish;

    logic [PW-1:0]      r_wx [N_OBJ];
    logic [PW-1:0]      r_wy [N_OBJ];
    logic [N_OBJ-1:0]   r_wdx, r_wdy;
    logic [PW-1:0]      r_px [N_OBJ];
    logic [PW-1:0]      r_py [N_OBJ];
    logic [N_OBJ-1:0]   r_pdx, r_pdy;

    logic [PW:0]        w_stx, w_sty;
    logic [AW-1:0]      w_sp;

    // One axis step: returns {new_dir, new_pos}, clamped to [0, lim].
    function automatic logic [PW:0] step_axis(
        input logic [PW-1:0] p,
        input logic          dir,
        input logic [AW-1:0] sp_pos,
        input logic [AW-1:0] sp_neg,
        input logic [AW-1:0] lim
    );
        logic [AW-1:0] p_w;
        logic [AW-1:0] n;
        p_w = AW'(p);
        n   = p_w + sp_pos;
        if (dir) begin
            if (n >= lim) step_axis = {1'b0, PW'(lim)};
            else          step_axis = {1'b1, PW'(n)};
        end else begin
            if (p_w <= sp_neg) step_axis = {1'b1, PW'(0)};
            else               step_axis = {1'b0, PW'(p_w - sp_neg)};
        end
    endfunction

    // Speeds are offsets from the square index: +x 7+i, -x 3+i, +y 6+i, -y 10+i.
    assign w_sp  = AW'(r_idx);
    assign w_stx = step_axis(r_wx[r_idx], r_wdx[r_idx], AW'(7) + w_sp, AW'(3) + w_sp, XMAX);
    assign w_sty = step_axis(r_wy[r_idx], r_wdy[r_idx], AW'(6) + w_sp, AW'(10) + w_sp, YMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_busy        <= 1'b0;
            r_update_done <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_busy        <= w_busy_nxt;
            r_update_done <= w_done_nxt;
            r_overrun     <= w_ovr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_step_en   = 1'b0;
        w_publish   = 1'b0;
        w_ovr_nxt   = r_overrun | (bus.frame_tick & (r_state != S_IDLE));
        case (r_state)
            S_IDLE: begin
                if (bus.frame_tick && !bus.freeze) begin
                    w_state_nxt = S_SWEEP;
                    w_idx_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_SWEEP: begin
                w_step_en = 1'b1;
                if (r_idx == LAST_IDX) begin
                    // Publish together with the last square so update_done marks visibility.
                    w_state_nxt = S_COMMIT;
                    w_publish   = 1'b1;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                end
            end
            S_COMMIT: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_OBJ; i++) begin
                r_wx[i]  <= PW'(40 + 100 * i);
                r_wy[i]  <= PW'(50 + 80 * i);
                r_wdx[i] <= 1'(i);
                r_wdy[i] <= 1'b1;
                r_px[i]  <= PW'(40 + 100 * i);
                r_py[i]  <= PW'(50 + 80 * i);
                r_pdx[i] <= 1'(i);
                r_pdy[i] <= 1'b1;
            end
        end else begin
            if (w_step_en) begin
                r_wx[r_idx]  <= w_stx[PW-1:0];
                r_wdx[r_idx] <= w_stx[PW];
                r_wy[r_idx]  <= w_sty[PW-1:0];
                r_wdy[r_idx] <= w_sty[PW];
            end
            if (w_publish) begin
                for (int i = 0; i < N_OBJ; i++) begin
                    if (IDX_W'(i) == r_idx) begin
                        r_px[i]  <= w_stx[PW-1:0];
                        r_pdx[i] <= w_stx[PW];
                        r_py[i]  <= w_sty[PW-1:0];
                        r_pdy[i] <= w_sty[PW];
                    end else begin
                        r_px[i]  <= r_wx[i];
                        r_pdx[i] <= r_wdx[i];
                        r_py[i]  <= r_wy[i];
                        r_pdy[i] <= r_wdy[i];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < N_OBJ; g++) begin : g_pack
        assign bus.obj_x[PW*g +: PW] = r_px[g];
        assign bus.obj_y[PW*g +: PW] = r_py[g];
        assign bus.obj_dir[2*g +: 2] = {r_pdy[g], r_pdx[g]};
    end

    assign bus.busy        = r_busy;
    assign bus.update_done = r_update_done;
    assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_square_motion_engine.sv
// Directed bench for square_motion_engine: hand-computed trajectories, bounces,
// overrun, freeze and mid-sweep reset.
module tb_square_motion_engine;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_bad;

    square_motion_engine_if #(.N_OBJ(5)) bus_if ();

    square_motion_engine #(
        .N_OBJ(5), .H_RES(640), .V_RES(480), .SIZE(80)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] px(input int i);
        return 32'(bus_if.obj_x[10*i +: 10]);
    endfunction

    function automatic logic [31:0] py(input int i);
        return 32'(bus_if.obj_y[10*i +: 10]);
    endfunction

    function automatic logic [31:0] pd(input int i);
        return 32'(bus_if.obj_dir[2*i +: 2]);
    endfunction

    // Pulse frame_tick, then wait (bounded) for update_done; lat counts negedges.
    task automatic do_frame(output int lat);
        @(negedge clk);
        bus_if.frame_tick = 1'b1;
        @(negedge clk);
        bus_if.frame_tick = 1'b0;
        lat = 1;
        while (!bus_if.update_done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int busy_cnt;
        int done_at;
        int done_cnt;
        logic saw;

        n_chk = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus_if.frame_tick = 1'b0;
        bus_if.freeze     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset table
        check_val("rst_x0", px(0), 40);
        check_val("rst_y0", py(0), 50);
        check_val("rst_x4", px(4), 440);
        check_val("rst_y4", py(4), 370);
        check_val("rst_dir0", pd(0), 2);
        check_val("rst_dir1", pd(1), 3);
        check_val("rst_busy", 32'(bus_if.busy), 0);
        check_val("rst_overrun", 32'(bus_if.overrun), 0);
        check_val("rst_done", 32'(bus_if.update_done), 0);

        // First frame: latency, busy window, no tearing
        @(negedge clk);
        bus_if.frame_tick = 1'b1;
        @(negedge clk);
        bus_if.frame_tick = 1'b0;
        busy_cnt = 0;
        done_at  = 0;
        for (int c = 1; c <= 10; c++) begin
            if (bus_if.busy) busy_cnt++;
            if (bus_if.update_done && done_at == 0) done_at = c;
            if (c == 5) check_val("x0_held_pre_commit", px(0), 40);
            @(negedge clk);
        end
        check_val("f1_busy_cycles", 32'(busy_cnt), 6);
        check_val("f1_done_at", 32'(done_at), 6);
        check_val("f1_x0", px(0), 37);
        check_val("f1_y0", py(0), 56);
        check_val("f1_x1", px(1), 148);
        check_val("f1_y1", py(1), 137);
        check_val("f1_x2", px(2), 235);
        check_val("f1_y2", py(2), 218);
        check_val("f1_x3", px(3), 350);
        check_val("f1_y3", py(3), 299);
        check_val("f1_x4", px(4), 433);
        check_val("f1_y4", py(4), 380);

        // Frames 2..100: edge bounces on squares 0 and 4
        for (int f = 2; f <= 100; f++) begin
            do_frame(lat);
            check_val("frame_latency", 32'(lat), 6);
            if (f == 3) begin
                check_val("f3_y4_clamp", py(4), 400);
                check_val("f3_dir4", pd(4), 0);
            end
            if (f == 4)  check_val("f4_y4", py(4), 386);
            if (f == 14) begin
                check_val("f14_x0_floor", px(0), 0);
                check_val("f14_dir0", pd(0), 3);
                check_val("f14_y0", py(0), 134);
            end
            if (f == 58) check_val("f58_y0", py(0), 398);
            if (f == 59) begin
                check_val("f59_y0_clamp", py(0), 400);
                check_val("f59_dir0", pd(0), 1);
            end
            if (f == 93) begin
                check_val("f93_x0", px(0), 553);
                check_val("f93_y0", py(0), 60);
            end
            if (f == 94) begin
                check_val("f94_x0_clamp", px(0), 560);
                check_val("f94_dir0", pd(0), 0);
            end
            if (f == 95) check_val("f95_x0", px(0), 557);
            if (f == 98) check_val("f98_y0", py(0), 10);
            if (f == 99) begin
                check_val("f99_y0_floor", py(0), 0);
                check_val("f99_dir0", pd(0), 2);
                check_val("f99_x0", px(0), 545);
            end
            if (f == 100) begin
                check_val("f100_y0", py(0), 6);
                check_val("f100_x0", px(0), 542);
            end
        end

        // Second tick two cycles into a sweep
        do_reset();
        @(negedge clk);
        bus_if.frame_tick = 1'b1;
        @(negedge clk);
        bus_if.frame_tick = 1'b0;
        done_cnt = 32'(bus_if.update_done);
        @(negedge clk);
        bus_if.frame_tick = 1'b1;
        done_cnt += 32'(bus_if.update_done);
        @(negedge clk);
        bus_if.frame_tick = 1'b0;
        for (int c = 0; c < 15; c++) begin
            done_cnt += 32'(bus_if.update_done);
            @(negedge clk);
        end
        check_val("ovr_done_count", 32'(done_cnt), 1);
        check_val("ovr_flag", 32'(bus_if.overrun), 1);
        check_val("ovr_x0", px(0), 37);
        check_val("ovr_y0", py(0), 56);
        check_val("ovr_busy", 32'(bus_if.busy), 0);

        // Freeze blocks ten ticks
        bus_if.freeze = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus_if.frame_tick = 1'b1;
            @(negedge clk);
            bus_if.frame_tick = 1'b0;
            saw |= bus_if.busy | bus_if.update_done;
            @(negedge clk);
            saw |= bus_if.busy | bus_if.update_done;
        end
        check_val("frz_no_activity", 32'(saw), 0);
        check_val("frz_x0", px(0), 37);
        check_val("frz_y0", py(0), 56);
        check_val("frz_overrun_sticky", 32'(bus_if.overrun), 1);
        bus_if.freeze = 1'b0;

        // Reset mid-sweep
        @(negedge clk);
        bus_if.frame_tick = 1'b1;
        @(negedge clk);
        bus_if.frame_tick = 1'b0;
        check_val("mid_busy_before", 32'(bus_if.busy), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_busy", 32'(bus_if.busy), 0);
        check_val("mid_rst_x0", px(0), 40);
        check_val("mid_rst_y0", py(0), 50);
        check_val("mid_rst_dir1", pd(1), 3);
        check_val("mid_rst_overrun", 32'(bus_if.overrun), 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            done_cnt += 32'(bus_if.update_done);
        end
        check_val("mid_rst_no_done", 32'(done_cnt), 0);
        check_val("mid_rst_x0_after", px(0), 40);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
